// File: rtl/hdmi_pll_lock_seq_if.sv
// Lock-sequencer signal bundle: PLL lock/restart in, PLL and HDMI resets,
// status flags, state code and lock-loss count out (master = sequencer).
interface hdmi_pll_lock_seq_if #(
  parameter int CNT_W = 8
);
  logic             pll_lock;
  logic             restart;
  logic             pll_reset;
  logic             hdmi_rst_n;
  logic             ready;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] loss_cnt;

  modport master (
    input  pll_lock,
    input  restart,
    output pll_reset,
    output hdmi_rst_n,
    output ready,
    output fault,
    output state,
    output loss_cnt
  );

  modport slave (
    output pll_lock,
    output restart,
    input  pll_reset,
    input  hdmi_rst_n,
    input  ready,
    input  fault,
    input  state,
    input  loss_cnt
  );
endinterface

// File: rtl/hdmi_pll_lock_seq.sv
// HDMI rPLL power-up/recovery sequencer on the 27 MHz reference clock.
// Ports: clk, resetn (sync, active-low), bus (master): pll_lock, restart in;
// pll_reset, hdmi_rst_n, ready, fault, state[2:0], loss_cnt out.
// Option: PLL_LOCK_GLITCH_FILT_EN adds a GLITCH_CYCLES lock-loss filter in RUN.
module hdmi_pll_lock_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int LOCK_STABLE   = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int GLITCH_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                 clk,
  input logic                 resetn,
  hdmi_pll_lock_seq_if.master bus
);

  localparam int M1 =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2 = (M1 > LOCK_STABLE) ? M1 : LOCK_STABLE;
  localparam int TMAX = (M2 > GLITCH_CYCLES) ? M2 : GLITCH_CYCLES;
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] T_RST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_TMO = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STB = TW'(LOCK_STABLE - 1);
`ifdef PLL_LOCK_GLITCH_FILT_EN
  localparam logic [TW-1:0] T_GLT = TW'(GLITCH_CYCLES - 1);
`endif
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST_PLL   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             pll_reset_q, pll_reset_d;
  logic             hdmi_rst_n_q, hdmi_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lock_s;

  assign lock_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_RST_PLL;
      timer_q      <= '0;
      retry_q      <= '0;
      loss_cnt_q   <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      pll_reset_q  <= 1'b1;
      hdmi_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      loss_cnt_q   <= loss_cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pll_reset_q  <= pll_reset_d;
      hdmi_rst_n_q <= hdmi_rst_n_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    retry_d    = retry_q;
    loss_cnt_d = loss_cnt_q;
    sync1_d    = bus.pll_lock;
    sync2_d    = sync1_q;
    if (bus.restart) begin
      state_d = S_RST_PLL;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RST_PLL: begin
          if (timer_q == T_RST) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
            timer_d = '0;
          end else if (timer_q == T_TMO) begin
            retry_d = retry_q + 1'b1;
            timer_d = '0;
            state_d = (retry_d == R_MAX) ? S_FAULT : S_RST_PLL;
          end
        end
        S_STABLE: begin
          // Any lock drop here restarts the wait; HDMI stays in reset.
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == T_STB) begin
            state_d = S_RUN;
            timer_d = '0;
            retry_d = '0;
          end
        end
        S_RUN: begin
`ifdef PLL_LOCK_GLITCH_FILT_EN
          // Timer doubles as the consecutive lock-low counter.
          if (lock_s) begin
            timer_d = '0;
          end else if (timer_q == T_GLT) begin
            state_d = S_RST_PLL;
            timer_d = '0;
            if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
          end
`else
          timer_d = '0;
          if (!lock_s) begin
            state_d = S_RST_PLL;
            if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
          end
`endif
        end
        S_FAULT: begin
          timer_d = '0;
        end
        default: begin
          state_d = S_RST_PLL;
          timer_d = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with it.
  always_comb begin
    pll_reset_d  = 1'b0;
    hdmi_rst_n_d = 1'b0;
    ready_d      = 1'b0;
    fault_d      = 1'b0;
    unique case (state_d)
      S_RST_PLL: begin
        pll_reset_d = 1'b1;
      end
      S_RUN: begin
        hdmi_rst_n_d = 1'b1;
        ready_d      = 1'b1;
      end
      S_FAULT: begin
        pll_reset_d = 1'b1;
        fault_d     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.pll_reset  = pll_reset_q;
  assign bus.hdmi_rst_n = hdmi_rst_n_q;
  assign bus.ready      = ready_q;
  assign bus.fault      = fault_q;
  assign bus.state      = state_q;
  assign bus.loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_hdmi_pll_lock_seq.sv
// Directed bench for hdmi_pll_lock_seq with RST_CYCLES=4, LOCK_TIMEOUT=20,
// LOCK_STABLE=8, MAX_RETRIES=2, GLITCH_CYCLES=3, CNT_W=8.
module tb_hdmi_pll_lock_seq;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  hdmi_pll_lock_seq_if #(.CNT_W(CNT_W)) bus();

  hdmi_pll_lock_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (2),
    .GLITCH_CYCLES(3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int bound, input string tag);
    int i;
    i = 0;
    while (!bus.ready && i < bound) begin
      tick();
      i++;
    end
    n_chk++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: ready=%b after %0d cycles, want 1", tag, bus.ready, i);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.pll_lock = 1'b0;
    bus.restart = 1'b0;
    tick();
    tick();
    n_chk++;
    if (bus.state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", bus.state);
    end
    n_chk++;
    if (bus.pll_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pll_reset: got %b want 1", bus.pll_reset);
    end
    n_chk++;
    if (bus.hdmi_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hdmi_rst_n: got %b want 0", bus.hdmi_rst_n);
    end
    n_chk++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0", bus.ready);
    end
    n_chk++;
    if (bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fault: got %b want 0", bus.fault);
    end
    n_chk++;
    if (bus.loss_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_loss_cnt: got %0d want 0", bus.loss_cnt);
    end
  endtask

  task automatic test_power_up();
    logic exp;
    resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k < 4);
      n_chk++;
      if (bus.pll_reset !== exp) begin
        n_fail++;
        $display("FAIL pu_pll_reset[%0d]: got %b want %b", k, bus.pll_reset, exp);
      end
    end
    n_chk++;
    if (bus.state !== 3'd1) begin
      n_fail++;
      $display("FAIL pu_wait_state: got %0d want 1", bus.state);
    end
    for (int k = 5; k <= 10; k++) tick();
    bus.pll_lock = 1'b1;
    // Edge k=1 is the first to sample pll_lock=1.
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp = (k == 11);
      n_chk++;
      if (bus.hdmi_rst_n !== exp) begin
        n_fail++;
        $display("FAIL pu_hdmi_rst_n[%0d]: got %b want %b", k, bus.hdmi_rst_n, exp);
      end
      n_chk++;
      if (bus.ready !== exp) begin
        n_fail++;
        $display("FAIL pu_ready[%0d]: got %b want %b", k, bus.ready, exp);
      end
      if (k == 2 || k == 3) begin
        n_chk++;
        if (bus.state !== 3'(k - 1)) begin
          n_fail++;
          $display("FAIL pu_state[%0d]: got %0d want %0d", k, bus.state, k - 1);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
`ifdef PLL_LOCK_GLITCH_FILT_EN
    bus.pll_lock = 1'b0;
    tick();
    tick();
    bus.pll_lock = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    n_chk++;
    if (bus.state !== 3'd3 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ll_short_drop: state=%0d ready=%b want 3/1", bus.state, bus.ready);
    end
    n_chk++;
    if (bus.loss_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL ll_short_cnt: got %0d want 0", bus.loss_cnt);
    end
    bus.pll_lock = 1'b0;
    tick();
    tick();
    tick();
    bus.pll_lock = 1'b1;
    tick();
`else
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    tick();
`endif
    n_chk++;
    if (bus.state !== 3'd3) begin
      n_fail++;
      $display("FAIL ll_pre_exit: state=%0d want 3", bus.state);
    end
    tick();
    n_chk++;
    if (bus.state !== 3'd0 || bus.hdmi_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL ll_exit: state=%0d hdmi_rst_n=%b want 0/0", bus.state, bus.hdmi_rst_n);
    end
    n_chk++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ll_exit_ready: got %b want 0", bus.ready);
    end
    n_chk++;
    if (bus.loss_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL ll_exit_cnt: got %0d want 1", bus.loss_cnt);
    end
    wait_ready(40, "ll_relock");
  endtask

  task automatic test_stable_glitch();
    logic exp;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    n_chk++;
    if (bus.state !== 3'd0 || bus.loss_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL sg_restart: state=%0d loss_cnt=%0d want 0/1", bus.state, bus.loss_cnt);
    end
    // STABLE entered at edge 5; count 5 is reached at edge 10.
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 8) bus.pll_lock = 1'b0;
      if (k == 9) bus.pll_lock = 1'b1;
      exp = (k == 20);
      n_chk++;
      if (bus.hdmi_rst_n !== exp) begin
        n_fail++;
        $display("FAIL sg_hdmi_rst_n[%0d]: got %b want %b", k, bus.hdmi_rst_n, exp);
      end
      if (k == 11) begin
        n_chk++;
        if (bus.state !== 3'd1) begin
          n_fail++;
          $display("FAIL sg_back_to_wait: got %0d want 1", bus.state);
        end
      end
      if (k == 12) begin
        n_chk++;
        if (bus.state !== 3'd2) begin
          n_fail++;
          $display("FAIL sg_back_to_stable: got %0d want 2", bus.state);
        end
      end
    end
  endtask

  task automatic test_timeout_fault();
    logic exp;
    bus.restart = 1'b1;
    bus.pll_lock = 1'b0;
    tick();
    bus.restart = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      exp = (k < 4) || (k >= 24 && k < 28) || (k >= 48);
      n_chk++;
      if (bus.pll_reset !== exp) begin
        n_fail++;
        $display("FAIL to_pll_reset[%0d]: got %b want %b", k, bus.pll_reset, exp);
      end
      if (k == 47) begin
        n_chk++;
        if (bus.state !== 3'd1 || bus.fault !== 1'b0) begin
          n_fail++;
          $display("FAIL to_before_fault: state=%0d fault=%b want 1/0", bus.state, bus.fault);
        end
      end
      if (k == 48) begin
        n_chk++;
        if (bus.state !== 3'd4 || bus.fault !== 1'b1) begin
          n_fail++;
          $display("FAIL to_fault: state=%0d fault=%b want 4/1", bus.state, bus.fault);
        end
      end
    end
    for (int k = 0; k < 5; k++) tick();
    n_chk++;
    if (bus.state !== 3'd4 || bus.fault !== 1'b1 || bus.pll_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL to_fault_hold: state=%0d fault=%b pll_reset=%b want 4/1/1",
               bus.state, bus.fault, bus.pll_reset);
    end
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    n_chk++;
    if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL to_restart: state=%0d fault=%b want 0/0", bus.state, bus.fault);
    end
  endtask

  task automatic test_restart_collision();
    // Entered right after a restart edge with lock low; 2nd timeout at 48.
    for (int k = 1; k <= 47; k++) tick();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    n_chk++;
    if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rc_collision: state=%0d fault=%b want 0/0", bus.state, bus.fault);
    end
    for (int k = 49; k <= 72; k++) begin
      tick();
      if (k == 71) begin
        n_chk++;
        if (bus.state !== 3'd1) begin
          n_fail++;
          $display("FAIL rc_wait: state=%0d want 1", bus.state);
        end
      end
      if (k == 72) begin
        n_chk++;
        if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin
          n_fail++;
          $display("FAIL rc_retry_cleared: state=%0d fault=%b want 0/0", bus.state, bus.fault);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.pll_lock = 1'b1;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    wait_ready(40, "mr_to_run");
    resetn = 1'b0;
    tick();
    n_chk++;
    if (bus.pll_reset !== 1'b1 || bus.hdmi_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_resets: pll_reset=%b hdmi_rst_n=%b want 1/0",
               bus.pll_reset, bus.hdmi_rst_n);
    end
    n_chk++;
    if (bus.state !== 3'd0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_state: state=%0d ready=%b want 0/0", bus.state, bus.ready);
    end
    n_chk++;
    if (bus.loss_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mr_loss_cnt: got %0d want 0", bus.loss_cnt);
    end
    resetn = 1'b1;
  endtask

  task automatic test_saturation();
    int j;
    for (int i = 0; i < 256; i++) begin
      wait_ready(40, "sat_ready");
      bus.pll_lock = 1'b0;
      j = 0;
      while (bus.ready && j < 10) begin
        tick();
        j++;
      end
      bus.pll_lock = 1'b1;
      if (i == 254) begin
        n_chk++;
        if (bus.loss_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL sat_reach: got %0d want 255", bus.loss_cnt);
        end
      end
    end
    n_chk++;
    if (bus.loss_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d want 255", bus.loss_cnt);
    end
  endtask

  initial begin
    bus.pll_lock = 1'b0;
    bus.restart = 1'b0;
    test_reset();
    test_power_up();
    test_lock_loss();
    test_stable_glitch();
    test_timeout_fault();
    test_restart_collision();
    test_mid_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
